// File: rtl/mem_access_controller.sv
// Initiator for the main-memory port: single-word reads/writes and burst reads,
// one valid/ready response per word, out-of-range requests rejected without access.
//
// state    | meaning
// IDLE     | waiting for a request, req_ready high
// RD_ISSUE | mem_addr presented, memory samples it on the next edge
// RD_CAP   | memory output valid, captured into rsp_rdata on the next edge
// WR       | mem_we high for this single cycle
// RESP     | response held until rsp_ready
module mem_access_controller #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 16384,
    parameter int LEN_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LEN_W-1:0]  req_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_last,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_CAP, WR, RESP} state_t;

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

    state_t             state;
    logic [LEN_W-1:0]   remaining;
    logic [ADDR_W:0]    end_addr;
    logic               out_of_range;

    // One extra bit so the last word of a burst can never wrap past the top.
    assign end_addr     = {1'b0, req_addr} + (req_write ? '0 : (ADDR_W+1)'(req_len));
    assign out_of_range = (end_addr >= DEPTH);
    assign req_ready    = (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (out_of_range) begin
                            remaining <= '0;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_last  <= 1'b1;
                            rsp_rdata <= '0;
                            state     <= RESP;
                        end else if (req_write) begin
                            remaining <= '0;
                            mem_addr  <= req_addr;
                            mem_wdata <= req_wdata;
                            mem_we    <= 1'b1;
                            state     <= WR;
                        end else begin
                            remaining <= req_len;
                            mem_addr  <= req_addr;
                            state     <= RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: state <= RD_CAP;
                RD_CAP: begin
                    rsp_rdata <= mem_rdata;
                    rsp_valid <= 1'b1;
                    rsp_last  <= (remaining == '0);
                    state     <= RESP;
                end
                WR: begin
                    mem_we    <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_last  <= 1'b1;
                    rsp_rdata <= '0;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (remaining != '0) begin
                            mem_addr  <= mem_addr + 1'b1;
                            remaining <= remaining - 1'b1;
                            state     <= RD_ISSUE;
                        end else begin
                            rsp_err <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_controller.sv
// Bench for mem_access_controller: behavioural registered memory, reference model
// and response scoreboard.
module tb_mem_access_controller;
    localparam int ADDR_W = 16, DATA_W = 16, MEM_DEPTH = 16384, LEN_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [LEN_W-1:0]  req_len = '0;
    logic              rsp_valid, rsp_ready = 1'b1, rsp_last, rsp_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              mem_we;

    mem_access_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_last(rsp_last), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [15:0] rdata; logic last; logic err; } exp_t;
    exp_t exp_q[$];

    bit [15:0] mem   [MEM_DEPTH];
    bit [15:0] model [MEM_DEPTH];
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = '0, pl_data = '0;

    int n_chk = 0, n_pass = 0, pop_cnt = 0, we_cnt = 0;

    // Synchronous memory: write on we, registered read of the presented address.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr[13:0]] <= pl_data;
        else if (mem_we && mem_addr < MEM_DEPTH) mem[mem_addr[13:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[13:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    exp_t        e;
    bit          prev_stall = 0;
    logic [15:0] prev_rdata;
    logic        prev_last;

    always @(negedge clk) begin
        if (reset) prev_stall = 0;
        else begin
            if (mem_we) we_cnt++;
            if (rsp_valid) begin
                if (prev_stall) begin
                    chk("stall_rdata", rsp_rdata, prev_rdata);
                    chk("stall_last", rsp_last, prev_last);
                end
                if (rsp_ready) begin
                    if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_last", rsp_last, e.last);
                        chk("rsp_err", rsp_err, e.err);
                        pop_cnt++;
                    end
                    prev_stall = 0;
                end else begin
                    prev_stall = 1;
                    prev_rdata = rsp_rdata;
                    prev_last  = rsp_last;
                end
            end else prev_stall = 0;
        end
    end

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pl_addr = a; pl_data = d; pl_en = 1'b1;
        model[a[13:0]] = d;
        @(posedge clk); #1 pl_en = 1'b0;
    endtask

    // Drives one request, pushes its expected responses at the accept edge and
    // returns the negedge index (1 = right after accept) of the first rsp_valid.
    task automatic send(input logic wr, input logic [15:0] a, input logic [15:0] d,
                        input logic [3:0] len, output int lat);
        bit acc = 0;
        exp_t x;
        lat = -1;
        req_write = wr; req_addr = a; req_wdata = d; req_len = len; req_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            if (req_ready) acc = 1;
        end
        if (!acc) begin
            chk("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (int'(a) + (wr ? 0 : int'(len)) >= MEM_DEPTH) begin
            x = '{rdata: 16'h0, last: 1'b1, err: 1'b1};
            exp_q.push_back(x);
        end else if (wr) begin
            model[a[13:0]] = d;
            x = '{rdata: 16'h0, last: 1'b1, err: 1'b0};
            exp_q.push_back(x);
        end else begin
            for (int i = 0; i <= int'(len); i++) begin
                x = '{rdata: model[(int'(a) + i) % MEM_DEPTH], last: (i == int'(len)), err: 1'b0};
                exp_q.push_back(x);
            end
        end
        #1 req_valid = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) done = 1;
        end
        if (!done) chk("drain_timeout", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_pops(input int target);
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk);
            if (pop_cnt >= target) done = 1;
        end
        if (!done) chk("pop_timeout", pop_cnt, target);
    endtask

    int lat, start, we0;

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        @(posedge clk); #1;

        preload(16'h0010, 16'hBEEF);
        for (int i = 0; i < 4; i++) preload(16'h0100 + 16'(i), 16'h00A0 + 16'(i));
        preload(16'h0200, 16'h5A5A);

        // single read
        send(1'b0, 16'h0010, 16'h0, 4'd0, lat);
        chk("rd_latency", lat, 3);
        drain();

        // write at the top address, then read it back
        we0 = we_cnt;
        send(1'b1, 16'h3FFF, 16'h1234, 4'd0, lat);
        chk("wr_latency", lat, 2);
        drain();
        chk("wr_we_cycles", we_cnt - we0, 1);
        send(1'b0, 16'h3FFF, 16'h0, 4'd0, lat);
        drain();

        // burst with a stall on word 2
        start = pop_cnt;
        send(1'b0, 16'h0100, 16'h0, 4'd3, lat);
        chk("burst_latency", lat, 3);
        wait_pops(start + 1);
        #1 rsp_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 rsp_ready = 1'b1;
        drain();
        chk("burst_count", pop_cnt - start, 4);

        // out-of-range requests
        we0 = we_cnt;
        send(1'b0, 16'h3FFF, 16'h0, 4'd1, lat);
        chk("err_rd_latency", lat, 1);
        drain();
        send(1'b1, 16'h4000, 16'hDEAD, 4'd0, lat);
        chk("err_wr_latency", lat, 1);
        drain();
        chk("err_no_we", we_cnt - we0, 0);
        chk("err_mem_kept", mem[14'h3FFF], 16'h1234);

        // reset during word 2 of a burst
        start = pop_cnt;
        send(1'b0, 16'h0100, 16'h0, 4'd3, lat);
        wait_pops(start + 1);
        #1 reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_mem_we", mem_we, 0);
        chk("mid_rst_req_ready", req_ready, 1);
        chk("mid_rst_mem_addr", mem_addr, 0);
        @(posedge clk); #1;
        send(1'b0, 16'h0010, 16'h0, 4'd0, lat);
        chk("post_rst_latency", lat, 3);
        drain();

        // second request held during a burst is served only afterwards
        start = pop_cnt;
        send(1'b0, 16'h0100, 16'h0, 4'd3, lat);
        send(1'b0, 16'h0200, 16'h0, 4'd0, lat);
        chk("held_req_latency", lat, 3);
        drain();
        chk("held_req_count", pop_cnt - start, 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
